clock_face_renderer: RTL and testbench

- Parametrised, double-buffered successor to the single-hand clock renderer.
- Draws up to four hands (hour, minute, second, alarm) into a back framebuffer, using an external sin/cos unit over a start/done handshake.
- Swaps front and back buffers at a frame boundary, so the display never blanks while a render is in progress.
- Sits between the timekeeping core and the VGA timing generator, and emits one scaled monochrome pixel per clock.

---
 rtl/clock_face_renderer.sv | 232 +++++++++++++++++++++++
 tb/tb_clock_face_renderer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_face_renderer.sv
// Double-buffered clock face renderer: draws up to four hands into the back
// framebuffer via an external sin/cos unit, swaps on frame_start, scans out the front.
module clock_face_renderer #(
  parameter int unsigned FB_DIM    = 64,
  parameter int unsigned SCALE     = 7,
  parameter int unsigned HOUR_LEN  = 22,
  parameter int unsigned MIN_LEN   = 31,
  parameter int unsigned SEC_LEN   = 27,
  parameter int unsigned ALARM_LEN = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        frame_start,
  input  logic [3:0]  hour,
  input  logic [5:0]  minute,
  input  logic [5:0]  second,
  input  logic [3:0]  al_hour,
  input  logic [5:0]  al_minute,
  input  logic [3:0]  hand_en,
  input  logic [9:0]  horizCounter,
  input  logic [9:0]  vertCounter,
  input  logic [9:0]  x_offset,
  input  logic [9:0]  y_offset,
  output logic        cord_start,
  output logic [8:0]  cord_angle,
  input  logic [15:0] cord_sin,
  input  logic [15:0] cord_cos,
  input  logic        cord_done,
  output logic        busy,
  output logic        swap_done,
  output logic        pixel_bw
);

  localparam int unsigned AW     = $clog2(FB_DIM);
  localparam int unsigned HALF   = FB_DIM / 2;
  localparam int unsigned ACTIVE = FB_DIM * SCALE;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_NEXT, S_ISSUE, S_WAIT, S_PLOT, S_SWAP
  } state_e;

  state_e state_q, state_d;

  logic              slow_q;
  logic              pending_q, pending_d;
  logic              front_q, front_d;
  logic [3:0]        hour_q, al_hour_q, en_q;
  logic [5:0]        min_q, sec_q, almin_q;
  logic [2:0]        hand_q, hand_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic [5:0]        r_q, r_d;
  logic [15:0]       sin_q, cos_q;
  logic [8:0]        angle_q, angle_d;
  logic              pixel_q;
  logic [FB_DIM-1:0] fb_q [2][FB_DIM];

  logic       rise, start, back_sel;
  logic [3:0] hand_ok;
  logic [5:0] len_sel;
  logic [8:0] ang_sel;

  assign rise     = slow_clk & ~slow_q;
  assign start    = (state_q == S_IDLE) && (rise || pending_q);
  assign back_sel = ~front_q;

  // An out-of-range minute kills both the hour and minute hands.
  assign hand_ok = en_q & {almin_q < 6'd60, sec_q < 6'd60, min_q < 6'd60, min_q < 6'd60};

  logic [3:0] hmod, almod;
  logic [8:0] ang_h, ang_m, ang_s, ang_a;

  always_comb begin
    hmod    = (hour_q >= 4'd12) ? hour_q - 4'd12 : hour_q;
    almod   = (al_hour_q >= 4'd12) ? al_hour_q - 4'd12 : al_hour_q;
    ang_h   = 9'(hmod) * 9'd30 + 9'(min_q >> 1);
    ang_m   = 9'(min_q) * 9'd6;
    ang_s   = 9'(sec_q) * 9'd6;
    ang_a   = 9'(almod) * 9'd30 + 9'(almin_q / 6'd10) * 9'd6;
    ang_sel = ang_h;
    len_sel = 6'(HOUR_LEN);
    unique case (hand_q[1:0])
      2'd0: begin ang_sel = ang_h; len_sel = 6'(HOUR_LEN);  end
      2'd1: begin ang_sel = ang_m; len_sel = 6'(MIN_LEN);   end
      2'd2: begin ang_sel = ang_s; len_sel = 6'(SEC_LEN);   end
      2'd3: begin ang_sel = ang_a; len_sel = 6'(ALARM_LEN); end
    endcase
  end

  logic signed [23:0] sin_ext, cos_ext, r_s, ps, pc, dx, dy, px, py;
  logic               plot_we;

  always_comb begin
    sin_ext = {{8{sin_q[15]}}, sin_q};
    cos_ext = {{8{cos_q[15]}}, cos_q};
    r_s     = {18'd0, r_q};
    ps      = sin_ext * r_s;
    pc      = cos_ext * r_s;
    dx      = (ps + 24'sd8192) >>> 14;
    dy      = (pc + 24'sd8192) >>> 14;
    px      = $signed(24'(HALF)) + dx;
    py      = $signed(24'(HALF)) - dy;
    plot_we = (state_q == S_PLOT) &&
              (px >= 24'sd0) && (px < $signed(24'(FB_DIM))) &&
              (py >= 24'sd0) && (py < $signed(24'(FB_DIM)));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: if (clr_q == AW'(FB_DIM - 1)) state_d = S_NEXT;
      S_NEXT: begin
        if (hand_q == 3'd4)           state_d = S_SWAP;
        else if (hand_ok[hand_q[1:0]]) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cord_done) state_d = S_PLOT;
      S_PLOT:  if (r_q == len_sel) state_d = S_NEXT;
      S_SWAP:  if (frame_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cord_start = (state_q == S_ISSUE);
    cord_angle = angle_q;
    busy       = (state_q != S_IDLE) || pending_q;
    swap_done  = (state_q == S_SWAP) && frame_start;
    pixel_bw   = pixel_q;
  end

  // Triggers seen while busy collapse into one pending render, consumed in IDLE.
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_IDLE) pending_d = 1'b0;
    else if (rise)         pending_d = 1'b1;
    front_d = front_q ^ swap_done;
    hand_d  = hand_q;
    clr_d   = clr_q;
    r_d     = r_q;
    angle_d = angle_q;
    unique case (state_q)
      S_IDLE:  begin hand_d = '0; clr_d = '0; end
      S_CLEAR: clr_d = clr_q + 1'b1;
      S_NEXT: begin
        if (hand_q != 3'd4) begin
          if (hand_ok[hand_q[1:0]]) angle_d = ang_sel;
          else                      hand_d  = hand_q + 3'd1;
        end
      end
      S_WAIT:  if (cord_done) r_d = 6'd1;
      S_PLOT: begin
        r_d = r_q + 6'd1;
        if (r_q == len_sel) hand_d = hand_q + 3'd1;
      end
      default: ;
    endcase
  end

  logic [9:0]    h_adj, v_adj;
  logic [AW-1:0] fb_x, fb_y;
  logic          active;

  always_comb begin
    h_adj  = horizCounter - x_offset;
    v_adj  = vertCounter - y_offset;
    active = (32'(h_adj) < ACTIVE) && (32'(v_adj) < ACTIVE);
    fb_x   = AW'(h_adj / 10'(SCALE));
    fb_y   = AW'(v_adj / 10'(SCALE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slow_q    <= 1'b0;
      pending_q <= 1'b0;
      front_q   <= 1'b0;
      hand_q    <= '0;
      clr_q     <= '0;
      r_q       <= '0;
      angle_q   <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      pixel_q   <= 1'b0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      al_hour_q <= '0;
      almin_q   <= '0;
      en_q      <= '0;
    end else begin
      slow_q    <= slow_clk;
      pending_q <= pending_d;
      front_q   <= front_d;
      hand_q    <= hand_d;
      clr_q     <= clr_d;
      r_q       <= r_d;
      angle_q   <= angle_d;
      pixel_q   <= active ? fb_q[front_q][fb_y][fb_x] : 1'b0;
      if (state_q == S_WAIT && cord_done) begin
        sin_q <= cord_sin;
        cos_q <= cord_cos;
      end
      if (start) begin
        hour_q    <= hour;
        min_q     <= minute;
        sec_q     <= second;
        al_hour_q <= al_hour;
        almin_q   <= al_minute;
        en_q      <= hand_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FB_DIM; i++) begin
        fb_q[0][i] <= '0;
        fb_q[1][i] <= '0;
      end
    end else begin
      if (state_q == S_CLEAR) fb_q[back_sel][clr_q] <= '0;
      if (plot_we) fb_q[back_sel][py[AW-1:0]][px[AW-1:0]] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_face_renderer.sv
// Scoreboard bench for clock_face_renderer with a fixed-latency sin/cos model
// and full front-buffer readback through the scaled display path.
module tb_clock_face_renderer;

  localparam int FB = 64;
  localparam int SC = 7;
  localparam int X_OFF = 1000;
  localparam int Y_OFF = 20;

  logic        clk, reset, slow_clk, frame_start;
  logic [3:0]  hour, al_hour, hand_en;
  logic [5:0]  minute, second, al_minute;
  logic [9:0]  horizCounter, vertCounter, x_offset, y_offset;
  logic        cord_start, cord_done, busy, swap_done, pixel_bw;
  logic [8:0]  cord_angle;
  logic [15:0] cord_sin, cord_cos;

  clock_face_renderer #(
    .FB_DIM(64), .SCALE(7), .HOUR_LEN(22), .MIN_LEN(31), .SEC_LEN(27), .ALARM_LEN(17)
  ) dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .frame_start(frame_start),
    .hour(hour), .minute(minute), .second(second), .al_hour(al_hour),
    .al_minute(al_minute), .hand_en(hand_en), .horizCounter(horizCounter),
    .vertCounter(vertCounter), .x_offset(x_offset), .y_offset(y_offset),
    .cord_start(cord_start), .cord_angle(cord_angle), .cord_sin(cord_sin),
    .cord_cos(cord_cos), .cord_done(cord_done), .busy(busy),
    .swap_done(swap_done), .pixel_bw(pixel_bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned req_cnt = 0, done_cnt = 0, swap_cnt = 0;
  logic [8:0]  exp_ang_q [$];
  logic [63:0] exp_row_q [$];
  logic [63:0] exp_img [FB];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sin/cos unit model: answers 16 cycles after each request.
  initial begin
    int          delay;
    logic [8:0]  cur_ang;
    logic [15:0] s, c;
    delay = 0;
    cur_ang = '0;
    cord_done = 1'b0;
    cord_sin = 16'h5a5a;
    cord_cos = 16'ha5a5;
    forever begin
      @(negedge clk);
      cord_done = 1'b0;
      cord_sin  = 16'h5a5a;
      cord_cos  = 16'ha5a5;
      if (cord_start === 1'b1) begin
        req_cnt++;
        cur_ang = cord_angle;
        delay = 16;
        if (exp_ang_q.size() > 0) check_val("cord_angle", 64'(cord_angle), 64'(exp_ang_q.pop_front()));
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          case (cur_ang)
            9'd0:    begin s = 16'sd0;      c = 16'sd16384;  end
            9'd90:   begin s = 16'sd16384;  c = 16'sd0;      end
            9'd180:  begin s = 16'sd0;      c = -16'sd16384; end
            9'd270:  begin s = -16'sd16384; c = 16'sd0;      end
            default: begin s = 16'sd0;      c = 16'sd0;      end
          endcase
          cord_done = 1'b1;
          cord_sin  = s;
          cord_cos  = c;
          done_cnt++;
          if (busy === 1'b1) check_val("angle_hold", 64'(cord_angle), 64'(cur_ang));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (swap_done === 1'b1) swap_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic trigger();
    slow_clk = 1'b1;
    repeat (2) tick();
    slow_clk = 1'b0;
    repeat (2) tick();
  endtask

  task automatic swap_wait(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      frame_start = 1'b1;
      @(negedge clk);
      seen = swap_done;
      tick();
      frame_start = 1'b0;
      repeat (4) tick();
    end
    check_val(tag, 64'(seen), 64'd1);
  endtask

  task automatic clear_img();
    for (int i = 0; i < FB; i++) exp_img[i] = '0;
  endtask

  task automatic set_row(input int row, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) exp_img[row][c] = 1'b1;
  endtask

  task automatic set_col(input int col, input int r0, input int r1);
    for (int r = r0; r <= r1; r++) exp_img[r][col] = 1'b1;
  endtask

  task automatic set_screen(input int fx, input int fy, input int sub);
    horizCounter = 10'(X_OFF + fx * SC + sub);
    vertCounter  = 10'(Y_OFF + fy * SC + (SC - 1 - sub));
  endtask

  // Reads the whole front buffer through the display path, one row per comparison.
  task automatic scan_front(input string tag);
    logic [63:0] obs;
    for (int row = 0; row < FB; row++) begin
      exp_row_q.push_back(exp_img[row]);
      obs = '0;
      for (int col = 0; col < FB; col++) begin
        set_screen(col, row, (col + row) % SC);
        tick();
        obs[col] = pixel_bw;
      end
      check_val($sformatf("%s_row%0d", tag, row), obs, exp_row_q.pop_front());
    end
  endtask

  task automatic check_pixel(input string tag, input int fx, input int fy, input logic exp);
    set_screen(fx, fy, 0);
    tick();
    check_val(tag, 64'(pixel_bw), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; slow_clk = 1'b0; frame_start = 1'b0;
    hour = '0; minute = '0; second = '0; al_hour = '0; al_minute = '0; hand_en = '0;
    x_offset = 10'(X_OFF); y_offset = 10'(Y_OFF);
    horizCounter = '0; vertCounter = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check_val("rst_pixel", 64'(pixel_bw), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_cord_start", 64'(cord_start), 64'd0);
    check_val("rst_swap_done", 64'(swap_done), 64'd0);
    check_val("rst_cord_angle", 64'(cord_angle), 64'd0);

    // Hour hand only at 3:00.
    hour = 4'd3; minute = 6'd0; second = 6'd0; hand_en = 4'b0001;
    exp_ang_q.push_back(9'd90);
    trigger();
    swap_wait("t1_swap");
    check_val("t1_swaps", 64'(swap_cnt), 64'd1);
    check_val("t1_reqs", 64'(req_cnt), 64'd1);
    clear_img();
    set_row(32, 33, 54);
    scan_front("t1");
    check_pixel("t1_px_on", 33, 32, 1'b1);
    check_pixel("t1_px_center", 32, 32, 1'b0);
    horizCounter = 10'(X_OFF + 64 * SC);
    vertCounter  = 10'(Y_OFF + 32 * SC);
    tick();
    check_val("t1_px_outside", 64'(pixel_bw), 64'd0);

    // Minute at 0 and second at 45.
    minute = 6'd0; second = 6'd45; hand_en = 4'b0110;
    exp_ang_q.push_back(9'd0);
    exp_ang_q.push_back(9'd270);
    trigger();
    swap_wait("t2_swap");
    check_val("t2_swaps", 64'(swap_cnt), 64'd2);
    check_val("t2_reqs", 64'(req_cnt), 64'd3);
    clear_img();
    set_col(32, 1, 31);
    set_row(32, 5, 31);
    scan_front("t2");

    // Extra triggers while busy merge into one pending render that uses new inputs.
    hour = 4'd3; minute = 6'd0; second = 6'd0; hand_en = 4'b0001;
    exp_ang_q.push_back(9'd90);
    trigger();
    repeat (3) tick();
    minute = 6'd60; second = 6'd15; al_hour = 4'd6; al_minute = 6'd0; hand_en = 4'b1111;
    exp_ang_q.push_back(9'd90);
    exp_ang_q.push_back(9'd180);
    trigger();
    trigger();
    swap_wait("t3_swap_a");
    check_val("t3_swaps_a", 64'(swap_cnt), 64'd3);
    clear_img();
    set_row(32, 33, 54);
    repeat (400) tick();
    check_val("t3_busy_pending", 64'(busy), 64'd1);
    scan_front("t3_hold");
    swap_wait("t3_swap_b");
    check_val("t3_swaps_b", 64'(swap_cnt), 64'd4);
    check_val("t3_reqs", 64'(req_cnt), 64'd6);
    clear_img();
    set_row(32, 33, 59);
    set_col(32, 33, 49);
    scan_front("t3_b");
    repeat (200) tick();
    check_val("t3_idle_busy", 64'(busy), 64'd0);
    check_val("t3_no_extra_req", 64'(req_cnt), 64'd6);
    check_val("t3_no_extra_swap", 64'(swap_cnt), 64'd4);

    // Reset while waiting on the sin/cos unit; its late answer must be ignored.
    hour = 4'd3; minute = 6'd0; hand_en = 4'b0001;
    exp_ang_q.push_back(9'd90);
    trigger();
    for (int k = 0; k < 300 && req_cnt < 7; k++) tick();
    check_val("t4_req_seen", 64'(req_cnt), 64'd7);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    check_val("t4_late_done", 64'(done_cnt), 64'd7);
    check_val("t4_busy", 64'(busy), 64'd0);
    check_val("t4_pixel", 64'(pixel_bw), 64'd0);
    check_val("t4_no_req", 64'(req_cnt), 64'd7);
    check_val("t4_swaps", 64'(swap_cnt), 64'd4);
    clear_img();
    scan_front("t4");
    check_val("ang_queue_left", 64'(exp_ang_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
